// File: rtl/thermometer_mask_generator.sv
// rtl/thermometer_mask_generator.sv - thermometer mask from a population count, streamed as beats
module thermometer_mask_generator #(
  parameter int WIDTH      = 1024,
  parameter int BEAT_W     = 64,
  parameter int COUNT_SIZE = $clog2(WIDTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [COUNT_SIZE:0] count_i,
  input  logic                count_val_i,
  output logic                count_ready_o,
  output logic [BEAT_W-1:0]   data_o,
  output logic                data_val_o,
  input  logic                data_ready_i,
  output logic                data_last_o,
  output logic                sat_o
);

  localparam int NBEATS = WIDTH / BEAT_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CNT_W  = COUNT_SIZE + 1;

  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] BEAT_C   = CNT_W'(BEAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_remaining;
  logic [IDX_W-1:0]   r_beat;
  logic               r_sat;
  logic               w_count_hs;
  logic               w_beat_hs;
  logic               w_last;
  logic [BEAT_W-1:0]  w_data;

  assign w_count_hs = count_val_i && (r_state == S_IDLE);
  assign w_beat_hs  = data_ready_i && (r_state == S_SEND);
  assign w_last     = (r_beat == LAST_IDX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_count_hs) w_next_state = S_SEND;
      S_SEND: if (w_beat_hs && w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // remaining never goes below zero: each beat consumes min(remaining, BEAT_W)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_remaining <= '0;
      r_beat      <= '0;
      r_sat       <= 1'b0;
    end else if (w_count_hs) begin
      r_remaining <= (count_i > WIDTH_C) ? WIDTH_C : count_i;
      r_sat       <= (count_i > WIDTH_C);
      r_beat      <= '0;
    end else if (w_beat_hs) begin
      r_remaining <= (r_remaining >= BEAT_C) ? (r_remaining - BEAT_C) : '0;
      r_beat      <= r_beat + 1'b1;
      if (w_last) begin
        r_sat <= 1'b0;
      end
    end
  end

  // bit i is set while more than i counts remain; saturates to all ones naturally
  always_comb begin
    w_data = '0;
    for (int i = 0; i < BEAT_W; i++) begin
      w_data[i] = (r_remaining > CNT_W'(i));
    end
  end

  assign count_ready_o = (r_state == S_IDLE);
  assign data_val_o    = (r_state == S_SEND);
  assign data_o        = data_val_o ? w_data : '0;
  assign data_last_o   = data_val_o && w_last;
  assign sat_o         = r_sat;

endmodule

// File: tb/tb_thermometer_mask_generator.sv
// tb/tb_thermometer_mask_generator.sv - directed bench for thermometer_mask_generator
module tb_thermometer_mask_generator;

  logic        clk_i;
  logic        rst_ni;
  logic [10:0] count_i;
  logic        count_val_i;
  logic        count_ready_o;
  logic [63:0] data_o;
  logic        data_val_o;
  logic        data_ready_i;
  logic        data_last_o;
  logic        sat_o;

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          t_acc;
  int          pop;
  logic [63:0] frame_beats [16];

  thermometer_mask_generator #(
    .WIDTH  (1024),
    .BEAT_W (64)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .count_i       (count_i),
    .count_val_i   (count_val_i),
    .count_ready_o (count_ready_o),
    .data_o        (data_o),
    .data_val_o    (data_val_o),
    .data_ready_i  (data_ready_i),
    .data_last_o   (data_last_o),
    .sat_o         (sat_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_exp(input int cnt, input int b);
    int c;
    int rem;
    c   = (cnt > 1024) ? 1024 : cnt;
    rem = c - 64 * b;
    if (rem <= 0) return 64'd0;
    if (rem >= 64) return {64{1'b1}};
    return (64'd1 << rem) - 64'd1;
  endfunction

  task automatic send_count(input int c);
    int waited;
    waited = 0;
    while (!count_ready_o && waited < 100) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (waited == 100) check("ready_timeout", 64'd0, 64'd1);
    count_i     = 11'(c);
    count_val_i = 1'b1;
    @(posedge clk_i); #1;
    t_acc       = cyc;
    count_val_i = 1'b0;
  endtask

  // mode 0: ready held high; 1: 5-cycle stalls on first/last beat plus random; 2: random stalls
  task automatic recv_frame(input int cnt, input int mode, output int popc);
    int          stalls;
    logic [63:0] exp;
    popc = 0;
    for (int b = 0; b < 16; b++) begin
      exp = beat_exp(cnt, b);
      if (mode == 1 && (b == 0 || b == 15)) stalls = 5;
      else if (mode >= 1) stalls = $urandom_range(0, 2);
      else stalls = 0;
      data_ready_i = 1'b0;
      for (int s = 0; s < stalls; s++) begin
        check("stall_data", data_o, exp);
        check("stall_val", 64'(data_val_o), 64'd1);
        check("stall_last", 64'(data_last_o), 64'(b == 15));
        @(posedge clk_i); #1;
      end
      data_ready_i = 1'b1;
      check("beat_data", data_o, exp);
      check("beat_val", 64'(data_val_o), 64'd1);
      check("beat_last", 64'(data_last_o), 64'(b == 15));
      check("beat_sat", 64'(sat_o), 64'(cnt > 1024));
      check("beat_cnt_rdy", 64'(count_ready_o), 64'd0);
      frame_beats[b] = data_o;
      popc += $countones(data_o);
      @(posedge clk_i); #1;
    end
    data_ready_i = 1'b0;
    check("end_cnt_rdy", 64'(count_ready_o), 64'd1);
    check("end_val", 64'(data_val_o), 64'd0);
    check("end_sat", 64'(sat_o), 64'd0);
  endtask

  initial begin
    int c;
    n_checks     = 0;
    n_errors     = 0;
    cyc          = 0;
    rst_ni       = 1'b0;
    count_i      = '0;
    count_val_i  = 1'b0;
    data_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cnt_rdy", 64'(count_ready_o), 64'd1);
    check("rst_val", 64'(data_val_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_last", 64'(data_last_o), 64'd0);
    check("rst_sat", 64'(sat_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    send_count(0);
    check("t1_first_val", 64'(data_val_o), 64'd1);
    recv_frame(0, 0, pop);
    check("t1_latency", 64'(cyc - t_acc), 64'd16);
    check("t1_pop", 64'(pop), 64'd0);

    send_count(100);
    recv_frame(100, 0, pop);
    check("t2_beat0", frame_beats[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_beat1", frame_beats[1], 64'h0000_000F_FFFF_FFFF);
    check("t2_beat2", frame_beats[2], 64'd0);
    check("t2_pop", 64'(pop), 64'd100);

    send_count(1024);
    recv_frame(1024, 0, pop);
    check("t3_pop1024", 64'(pop), 64'd1024);
    send_count(2047);
    check("t3_sat_first", 64'(sat_o), 64'd1);
    recv_frame(2047, 0, pop);
    check("t3_pop2047", 64'(pop), 64'd1024);
    check("t3_beat15", frame_beats[15], 64'hFFFF_FFFF_FFFF_FFFF);

    send_count(64);
    count_i     = 11'd5;
    count_val_i = 1'b1;
    recv_frame(64, 1, pop);
    check("t4_pop", 64'(pop), 64'd64);
    check("t4_beat0", frame_beats[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4_beat1", frame_beats[1], 64'd0);
    @(posedge clk_i); #1;
    count_val_i = 1'b0;
    check("t4_late_accept", 64'(data_val_o), 64'd1);
    recv_frame(5, 0, pop);
    check("t4_beat0_5", frame_beats[0], 64'h1F);

    send_count(500);
    data_ready_i = 1'b1;
    repeat (7) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("t5_rst_val", 64'(data_val_o), 64'd0);
    check("t5_rst_cnt_rdy", 64'(count_ready_o), 64'd1);
    check("t5_rst_data", data_o, 64'd0);
    check("t5_rst_last", 64'(data_last_o), 64'd0);
    check("t5_rst_sat", 64'(sat_o), 64'd0);
    data_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    send_count(3);
    recv_frame(3, 0, pop);
    check("t5_beat0", frame_beats[0], 64'h7);
    check("t5_pop", 64'(pop), 64'd3);

    for (int f = 0; f < 20; f++) begin
      c = $urandom_range(0, 1100);
      send_count(c);
      recv_frame(c, 2, pop);
      check("t6_pop", 64'(pop), 64'((c > 1024) ? 1024 : c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
